// File: rtl/frac_baud_pkg.sv
// Shared defaults for the fractional baud generator and a divisor calculator.
// calc_div returns {integer, fraction} in units of 1/2^FRAC_W_DEF cycle, rounded to nearest.
package frac_baud_pkg;

    localparam int INT_W_DEF    = 16;
    localparam int FRAC_W_DEF   = 4;
    localparam int OVS_DEF      = 16;
    localparam int DEF_INT_DEF  = 326;
    localparam int DEF_FRAC_DEF = 0;
    localparam int MIN_DIV      = 2;

    typedef struct packed {
        logic [INT_W_DEF-1:0]  int_part;
        logic [FRAC_W_DEF-1:0] frac_part;
    } div_cfg_t;

    function automatic div_cfg_t calc_div(
        input longint unsigned f_clk,
        input longint unsigned baud,
        input longint unsigned ovs
    );
        longint unsigned den_v;
        longint unsigned q_v;
        den_v = baud * ovs;
        if (den_v == 64'd0) begin
            q_v = 64'd0;
        end else begin
            q_v = ((f_clk << FRAC_W_DEF) + (den_v >> 1)) / den_v;
        end
        return q_v[INT_W_DEF+FRAC_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/frac_baud_gen_if.sv
// Control/status and tick bundle between the baud generator and its UART user.
interface frac_baud_gen_if #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic              sync;
    logic [INT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_busy;
    logic              cfg_err;
    logic              tick_ovs;
    logic              tick_mid;
    logic              tick_bit;

    modport master (
        output en, sync, div_int, div_frac, div_load,
        input  div_busy, cfg_err, tick_ovs, tick_mid, tick_bit
    );

    modport slave (
        input  en, sync, div_int, div_frac, div_load,
        output div_busy, cfg_err, tick_ovs, tick_mid, tick_bit
    );
endinterface

// File: rtl/frac_period_ctr.sv
// Period counter with fractional accumulator; tc marks the last cycle of each period.
// Period = div_int + carry(acc + div_frac); acc advances only when a period completes.
module frac_period_ctr #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tc
);
    localparam logic [INT_W:0] ONE_C = {{INT_W{1'b0}}, 1'b1};

    logic [INT_W:0]  cnt_r;
    logic [FRAC_W-1:0] acc_r;
    logic [FRAC_W:0] sum_s;
    logic [INT_W:0]  period_s;
    logic [INT_W:0]  cnt_inc_s;

    // Current period length and terminal-count detect; >= keeps a shortened divisor from overrunning
    always_comb begin
        sum_s     = {1'b0, acc_r} + {1'b0, div_frac};
        period_s  = {1'b0, div_int} + {{INT_W{1'b0}}, sum_s[FRAC_W]};
        cnt_inc_s = cnt_r + ONE_C;
        tc        = en & ~clr & (cnt_inc_s >= period_s);
    end

    // Cycle counter and fractional accumulator
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            acc_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
            acc_r <= '0;
        end else if (tc) begin
            cnt_r <= '0;
            acc_r <= sum_s[FRAC_W-1:0];
        end else if (en) begin
            cnt_r <= cnt_inc_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/frac_baud_gen.sv
// Fractional-N baud tick generator: registered oversample, mid-bit and bit enable pulses.
// Build option FRAC_BAUD_CLKOUT_EN adds clk_out, a registered bit-rate square wave (data, not a clock).
module frac_baud_gen
    import frac_baud_pkg::*;
#(
    parameter int INT_W    = INT_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int OVS      = OVS_DEF,
    parameter int DEF_INT  = DEF_INT_DEF,
    parameter int DEF_FRAC = DEF_FRAC_DEF
) (
    input  logic           clk_in,
    input  logic           rst,
    frac_baud_gen_if.slave bus
`ifdef FRAC_BAUD_CLKOUT_EN
    ,
    output logic           clk_out
`endif
);
    localparam int OVS_W = $clog2(OVS);
    localparam logic [INT_W-1:0]  MIN_DIV_C  = INT_W'(MIN_DIV);
    localparam logic [INT_W-1:0]  DEF_INT_C  = INT_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] DEF_FRAC_C = FRAC_W'(DEF_FRAC);
    localparam logic [OVS_W-1:0]  MID_C      = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0]  LAST_C     = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0]  ONE_C      = OVS_W'(1);

    logic [INT_W-1:0]  shadow_int_r;
    logic [FRAC_W-1:0] shadow_frac_r;
    logic              busy_r;
    logic [INT_W-1:0]  act_int_r;
    logic [FRAC_W-1:0] act_frac_r;
    logic              err_r;
    logic [OVS_W-1:0]  ovs_cnt_r;
    logic              tick_ovs_r;
    logic              tick_mid_r;
    logic              tick_bit_r;

    logic tc_s;
    logic sync_s;
    logic apply_s;
    logic shadow_lo_s;
    logic mid_hit_s;
    logic bit_hit_s;

    // Shadow applies at a period boundary, at sync, or at once while frozen
    always_comb begin
        sync_s      = bus.en & bus.sync;
        apply_s     = busy_r & (tc_s | sync_s | ~bus.en);
        shadow_lo_s = (shadow_int_r < MIN_DIV_C);
        mid_hit_s   = tc_s & (ovs_cnt_r == MID_C);
        bit_hit_s   = tc_s & (ovs_cnt_r == LAST_C);
    end

    frac_period_ctr #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_period_ctr (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (bus.en),
        .clr      (sync_s),
        .div_int  (act_int_r),
        .div_frac (act_frac_r),
        .tc       (tc_s)
    );

    // Shadow capture; a load in the apply cycle keeps busy set for the newer value
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            shadow_int_r  <= DEF_INT_C;
            shadow_frac_r <= DEF_FRAC_C;
            busy_r        <= 1'b0;
        end else if (bus.div_load) begin
            shadow_int_r  <= bus.div_int;
            shadow_frac_r <= bus.div_frac;
            busy_r        <= 1'b1;
        end else if (apply_s) begin
            busy_r        <= 1'b0;
        end else begin
            busy_r        <= busy_r;
        end
    end

    // Active divisor with clamp to MIN_DIV and sticky error
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            act_int_r  <= DEF_INT_C;
            act_frac_r <= DEF_FRAC_C;
            err_r      <= 1'b0;
        end else if (apply_s) begin
            act_int_r  <= shadow_lo_s ? MIN_DIV_C : shadow_int_r;
            act_frac_r <= shadow_frac_r;
            err_r      <= err_r | shadow_lo_s;
        end else begin
            act_int_r  <= act_int_r;
        end
    end

    // Oversample counter and registered tick decode
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            ovs_cnt_r  <= '0;
            tick_ovs_r <= 1'b0;
            tick_mid_r <= 1'b0;
            tick_bit_r <= 1'b0;
        end else if (sync_s) begin
            ovs_cnt_r  <= '0;
            tick_ovs_r <= 1'b0;
            tick_mid_r <= 1'b0;
            tick_bit_r <= 1'b0;
        end else begin
            ovs_cnt_r  <= tc_s ? (ovs_cnt_r + ONE_C) : ovs_cnt_r;
            tick_ovs_r <= tc_s;
            tick_mid_r <= mid_hit_s;
            tick_bit_r <= bit_hit_s;
        end
    end

    assign bus.div_busy = busy_r;
    assign bus.cfg_err  = err_r;
    assign bus.tick_ovs = tick_ovs_r;
    assign bus.tick_mid = tick_mid_r;
    assign bus.tick_bit = tick_bit_r;

`ifdef FRAC_BAUD_CLKOUT_EN
    logic clk_out_r;

    // Square wave: rises with tick_bit, falls with tick_mid
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            clk_out_r <= 1'b0;
        end else if (bit_hit_s) begin
            clk_out_r <= 1'b1;
        end else if (mid_hit_s) begin
            clk_out_r <= 1'b0;
        end else begin
            clk_out_r <= clk_out_r;
        end
    end

    assign clk_out = clk_out_r;
`else
    // debug square wave not built
`endif
endmodule

// File: tb/tb_frac_baud_gen.sv
// Directed, table-driven bench for frac_baud_gen (default parameters, 326.0 after reset).
module tb_frac_baud_gen;
    import frac_baud_pkg::*;

    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    frac_baud_gen_if #(.INT_W(16), .FRAC_W(4)) bus ();
`ifdef FRAC_BAUD_CLKOUT_EN
    logic clk_out;
`endif

    frac_baud_gen #(
        .INT_W(16), .FRAC_W(4), .OVS(16), .DEF_INT(326), .DEF_FRAC(0)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
`ifdef FRAC_BAUD_CLKOUT_EN
        ,
        .clk_out(clk_out)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] di;
        logic [3:0]  df;
        int          p0, p1, p2, p3;
        int          err;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.sync     = 1'b0;
        bus.div_load = 1'b0;
        bus.div_int  = 16'd0;
        bus.div_frac = 4'd0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic load(input logic [15:0] di, input logic [3:0] df);
        bus.div_int  = di;
        bus.div_frac = df;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
    endtask

    // edges until the next tick_ovs, or -1 if none within limit
    task automatic to_tick(input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            step();
            n++;
            seen = bus.tick_ovs;
        end
        if (!seen) n = -1;
    endtask

    initial begin
        int n, ep[4];
        int first_ovs, first_mid, first_bit, mid2, n_ovs, bad, ticks;

        vecs[0] = '{16'd326, 4'd0,  326, 326, 326, 326, 0};
        vecs[1] = '{16'd10,  4'd8,  10,  11,  10,  11,  0};
        vecs[2] = '{16'd20,  4'd0,  20,  20,  20,  20,  0};
        vecs[3] = '{16'd1,   4'd0,  2,   2,   2,   2,   1};
        vecs[4] = '{16'd0,   4'd0,  2,   2,   2,   2,   1};
        vecs[5] = '{16'd2,   4'd0,  2,   2,   2,   2,   0};
        vecs[6] = '{16'd3,   4'd4,  3,   3,   3,   4,   0};
        vecs[7] = '{16'd5,   4'd15, 5,   6,   6,   6,   0};
        vecs[8] = '{16'd1,   4'd8,  2,   3,   2,   3,   1};

        // reset state
        do_reset();
        rst = 1'b0;
        step();
        check("reset_outputs", int'({bus.tick_ovs, bus.tick_mid, bus.tick_bit,
                                     bus.div_busy, bus.cfg_err}), 0);
`ifdef FRAC_BAUD_CLKOUT_EN
        check("reset_clk_out", int'(clk_out), 0);
`endif

        // defaults: ovs every 326, mid at 2608, bit at 5216
        do_reset();
        bus.en = 1'b1;
        first_ovs = -1; first_mid = -1; first_bit = -1; mid2 = -1; n_ovs = 0;
        for (int c = 1; c <= 8000; c++) begin
            step();
            if (bus.tick_ovs) begin
                n_ovs++;
                if (first_ovs < 0) first_ovs = c;
            end
            if (bus.tick_mid) begin
                if (first_mid < 0) first_mid = c;
                else if (mid2 < 0) mid2 = c;
            end
            if (bus.tick_bit && first_bit < 0) first_bit = c;
        end
        check("def_first_ovs", first_ovs, 326);
        check("def_first_mid", first_mid, 2608);
        check("def_first_bit", first_bit, 5216);
        check("def_mid_after_bit", mid2, 7824);
        check("def_ovs_count", n_ovs, 24);

        // table: load while frozen, then four periods
        for (int i = 0; i < 9; i++) begin
            do_reset();
            load(vecs[i].di, vecs[i].df);
            check($sformatf("v%0d_busy_set", i), int'(bus.div_busy), 1);
            step();
            check($sformatf("v%0d_busy_clr", i), int'(bus.div_busy), 0);
            ep[0] = vecs[i].p0; ep[1] = vecs[i].p1; ep[2] = vecs[i].p2; ep[3] = vecs[i].p3;
            bus.en = 1'b1;
            for (int k = 0; k < 4; k++) begin
                to_tick(1000, n);
                check($sformatf("v%0d_period%0d", i, k), n, ep[k]);
            end
            check($sformatf("v%0d_cfg_err", i), int'(bus.cfg_err), vecs[i].err);
        end

        // 10.5: 16 ticks in exactly 168 cycles
        do_reset();
        load(16'd10, 4'd8);
        step();
        bus.en = 1'b1;
        ticks = 0; n = -1;
        for (int c = 1; c <= 400 && n < 0; c++) begin
            step();
            if (bus.tick_ovs) ticks++;
            if (ticks == 16) n = c;
        end
        check("frac_16_ticks_cycles", n, 168);

        // load mid-period: busy until next tick, then 20-cycle period
        do_reset();
        bus.en = 1'b1;
        repeat (100) step();
        load(16'd20, 4'd0);
        check("mid_load_busy", int'(bus.div_busy), 1);
        bad = 0; n = 0;
        while (n < 400 && !bus.tick_ovs) begin
            step();
            n++;
            if (!bus.tick_ovs && !bus.div_busy) bad++;
        end
        check("mid_load_tick_at", n, 225);
        check("mid_load_busy_early_clear", bad, 0);
        check("mid_load_busy_at_tick", int'(bus.div_busy), 0);
        to_tick(1000, n);
        check("mid_load_new_period", n, 20);

        // reset discards a pending load
        do_reset();
        bus.en = 1'b1;
        repeat (50) step();
        load(16'd20, 4'd0);
        rst = 1'b0;
        step();
        check("rst_clears_busy", int'(bus.div_busy), 0);
        rst = 1'b1;
        to_tick(1000, n);
        check("rst_period_default", n, 326);

        // cfg_err is sticky until reset
        do_reset();
        load(16'd1, 4'd0);
        step();
        load(16'd20, 4'd0);
        step();
        check("cfg_err_sticky", int'(bus.cfg_err), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("cfg_err_rst", int'(bus.cfg_err), 0);

        // sync at cnt=100 after three ticks restarts period and ovs_cnt
        do_reset();
        bus.en = 1'b1;
        repeat (3 * 326 + 100) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync_no_tick", int'(bus.tick_ovs), 0);
        first_ovs = -1; first_mid = -1;
        for (int c = 1; c <= 3000; c++) begin
            step();
            if (bus.tick_ovs && first_ovs < 0) first_ovs = c;
            if (bus.tick_mid && first_mid < 0) first_mid = c;
        end
        check("sync_first_ovs", first_ovs, 326);
        check("sync_first_mid", first_mid, 2608);

        // sync on terminal count wins
        do_reset();
        bus.en = 1'b1;
        repeat (325) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync_tc_suppressed", int'(bus.tick_ovs), 0);
        to_tick(1000, n);
        check("sync_tc_next", n, 326);

        // sync applies pending shadow
        do_reset();
        bus.en = 1'b1;
        repeat (10) step();
        load(16'd20, 4'd0);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync_apply_busy", int'(bus.div_busy), 0);
        to_tick(1000, n);
        check("sync_apply_period", n, 20);

        // en=0 for 50 cycles stretches the period; sync ignored meanwhile
        do_reset();
        bus.en = 1'b1;
        repeat (100) step();
        bus.en = 1'b0;
        ticks = 0;
        for (int c = 0; c < 50; c++) begin
            bus.sync = (c == 25);
            step();
            if (bus.tick_ovs) ticks++;
        end
        bus.sync = 1'b0;
        check("freeze_no_ticks", ticks, 0);
        bus.en = 1'b1;
        to_tick(1000, n);
        check("freeze_stretch", n + 150, 376);

`ifdef FRAC_BAUD_CLKOUT_EN
        // div 4.0: clk_out 32 high, 32 low
        do_reset();
        load(16'd4, 4'd0);
        step();
        bus.en = 1'b1;
        n = 0;
        while (!clk_out && n < 500) begin step(); n++; end
        check("clk_out_first_rise", n, 64);
        n = 0;
        while (clk_out && n < 200) begin step(); n++; end
        check("clk_out_high", n, 32);
        n = 0;
        while (!clk_out && n < 200) begin step(); n++; end
        check("clk_out_low", n, 32);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
